// File: rtl/seg7_pkg.sv
// Shared definitions for the seven-segment display path: width helper,
// anode-off constant and segment bit positions used by the digit decoders.
package seg7_pkg;

    // Bits needed to hold values 0..value-1, never less than one bit.
    function automatic int clog2(input int value);
        int w;
        w = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < value) w = i + 1;
        end
        return w;
    endfunction

    localparam logic [31:0] ANODE_OFF = 32'hFFFF_FFFF;

    localparam int SEG_W_DEFAULT = 7;
    localparam int SEG_A         = 0;
    localparam int SEG_B         = 1;
    localparam int SEG_C         = 2;
    localparam int SEG_D         = 3;
    localparam int SEG_E         = 4;
    localparam int SEG_F         = 5;
    localparam int SEG_G         = 6;

endpackage

// File: rtl/seg7_prescaler.sv
// Refresh-rate divider: asserts tick for one cycle every PRESCALE enabled cycles.
module seg7_prescaler
    import seg7_pkg::*;
#(
    parameter int PRESCALE = 16384
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic tick
);

    localparam int               CNT_W   = clog2(PRESCALE);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(PRESCALE - 1);

    logic [CNT_W-1:0] cnt;

    assign tick = en && (cnt == CNT_MAX);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/seg7_scan_mux.sv
// Self-scanning common-anode seven-segment multiplexer with per-digit blanking,
// global enable and anti-ghosting dead time after every digit switch.
module seg7_scan_mux
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int SEG_W      = 7,
    parameter int PRESCALE   = 16384,
    parameter int DEADTIME   = 2
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           en,
    input  logic [NUM_DIGITS*SEG_W-1:0]    di,
    input  logic [NUM_DIGITS-1:0]          dp_in,
    input  logic [NUM_DIGITS-1:0]          blank_mask,
    output logic [NUM_DIGITS-1:0]          an,
    output logic [SEG_W-1:0]               seg_out,
    output logic                           dp_out,
    output logic [clog2(NUM_DIGITS)-1:0]   digit_idx
);

    localparam int                    IDX_W     = clog2(NUM_DIGITS);
    localparam int                    DEAD_W    = clog2(DEADTIME + 1);
    localparam logic [IDX_W-1:0]      LAST_IDX  = IDX_W'(NUM_DIGITS - 1);
    localparam logic [DEAD_W-1:0]     DEAD_LOAD = DEAD_W'(DEADTIME);
    localparam logic [NUM_DIGITS-1:0] OFF       = ANODE_OFF[NUM_DIGITS-1:0];

    logic                  tick;
    logic [DEAD_W-1:0]     dead;
    logic [SEG_W-1:0]      seg_sel;
    logic                  dp_sel;
    logic                  dark;
    logic [NUM_DIGITS-1:0] an_sel;

    seg7_prescaler #(
        .PRESCALE(PRESCALE)
    ) u_prescaler (
        .clk (clk),
        .rst (rst),
        .en  (en),
        .tick(tick)
    );

    // Slot index and dead-time counter both freeze while en is low.
    always_ff @(posedge clk) begin
        if (rst) begin
            digit_idx <= '0;
            dead      <= '0;
        end else if (tick) begin
            digit_idx <= (digit_idx == LAST_IDX) ? '0 : digit_idx + IDX_W'(1);
            dead      <= DEAD_LOAD;
        end else if (en && dead != '0) begin
            dead      <= dead - DEAD_W'(1);
        end
    end

    always_comb begin
        seg_sel = di[digit_idx*SEG_W +: SEG_W];
        dp_sel  = dp_in[digit_idx];
        dark    = !en || (dead != '0) || blank_mask[digit_idx];
        an_sel  = ~(NUM_DIGITS'(1) << digit_idx);
    end

    // Segment data keeps following the selected digit even while its anode is dark.
    always_ff @(posedge clk) begin
        if (rst) begin
            an      <= OFF;
            seg_out <= '0;
            dp_out  <= 1'b0;
        end else begin
            an      <= dark ? OFF : an_sel;
            seg_out <= seg_sel;
            dp_out  <= dp_sel;
        end
    end

endmodule

// File: tb/tb_seg7_scan_mux.sv
// Scoreboard bench for seg7_scan_mux: directed stimulus queues hand-derived
// per-cycle expectations, a negedge monitor pops and compares them.
module tb_seg7_scan_mux;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, rst2, en;
    logic [27:0] di;
    logic [3:0]  dp_in, blank_mask;
    logic [3:0]  an, an2;
    logic [6:0]  seg_out, seg2;
    logic        dp_out, dp2;
    logic [1:0]  digit_idx, idx2;

    seg7_scan_mux #(.NUM_DIGITS(4), .SEG_W(7), .PRESCALE(4), .DEADTIME(1)) dut (
        .clk(clk), .rst(rst), .en(en), .di(di), .dp_in(dp_in), .blank_mask(blank_mask),
        .an(an), .seg_out(seg_out), .dp_out(dp_out), .digit_idx(digit_idx)
    );

    seg7_scan_mux #(.NUM_DIGITS(4), .SEG_W(7), .PRESCALE(2), .DEADTIME(0)) dut2 (
        .clk(clk), .rst(rst2), .en(en), .di(di), .dp_in(dp_in), .blank_mask(blank_mask),
        .an(an2), .seg_out(seg2), .dp_out(dp2), .digit_idx(idx2)
    );

    typedef struct {
        int         cyc;
        int         unit;
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
        logic [1:0] idx;
        int         phase;
    } exp_t;

    exp_t       q[$];
    int         cyc = 0;
    int         checks = 0;
    int         errors = 0;
    int         phase = 0;
    logic [3:0] lit_an [4];
    logic [6:0] segs [4];
    logic [3:0] dp_pat;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic string pname(input int p);
        case (p)
            1: return "reset";
            2: return "rotation";
            3: return "blanking";
            4: return "enable";
            5: return "reset_mid";
            6: return "data_change";
            7: return "no_deadtime";
            default: return "misc";
        endcase
    endfunction

    // Expectation for the outputs visible after the next active edge.
    task automatic step(input int unit, input logic [3:0] a, input logic [6:0] s,
                        input logic d, input logic [1:0] i);
        exp_t e;
        e.cyc = cyc + 1; e.unit = unit; e.an = a; e.seg = s; e.dp = d; e.idx = i;
        e.phase = phase;
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    // Cycles j0..j1 of a 4-cycle slot for digit d; index advances on the slot's last edge.
    task automatic slot(input int d, input bit dark, input bit blanked, input int j0, input int j1);
        for (int j = j0; j <= j1; j++) begin
            step(0, (blanked || (dark && j == 0)) ? 4'b1111 : lit_an[d], segs[d], dp_pat[d],
                 (j == 3) ? 2'((d + 1) % 4) : 2'(d));
        end
    endtask

    initial begin : monitor
        exp_t       cur;
        logic [3:0] g_an;
        logic [6:0] g_seg;
        logic       g_dp;
        logic [1:0] g_idx;
        forever begin
            @(negedge clk);
            while (q.size() > 0 && q[0].cyc <= cyc) begin
                cur = q.pop_front();
                if (cur.unit == 0) begin
                    g_an = an;  g_seg = seg_out; g_dp = dp_out; g_idx = digit_idx;
                end else begin
                    g_an = an2; g_seg = seg2;    g_dp = dp2;    g_idx = idx2;
                end
                checks++;
                if (cur.cyc != cyc || g_an !== cur.an || g_seg !== cur.seg ||
                    g_dp !== cur.dp || g_idx !== cur.idx) begin
                    errors++;
                    $display("FAIL %s cyc=%0d unit=%0d got an=%b seg=%h dp=%b idx=%0d want an=%b seg=%h dp=%b idx=%0d",
                             pname(cur.phase), cyc, cur.unit, g_an, g_seg, g_dp, g_idx,
                             cur.an, cur.seg, cur.dp, cur.idx);
                end
            end
        end
    end

    initial begin
        lit_an[0] = 4'b1110; lit_an[1] = 4'b1101; lit_an[2] = 4'b1011; lit_an[3] = 4'b0111;
        segs[0] = 7'h3F; segs[1] = 7'h06; segs[2] = 7'h5B; segs[3] = 7'h4F;
        dp_pat     = 4'b0101;
        rst        = 1'b1;
        rst2       = 1'b1;
        en         = 1'b1;
        di         = {7'h4F, 7'h5B, 7'h06, 7'h3F};
        dp_in      = dp_pat;
        blank_mask = 4'b0000;
        @(posedge clk);
        #1;

        phase = 1;
        repeat (3) step(0, 4'b1111, 7'h00, 1'b0, 2'd0);
        rst = 1'b0;

        phase = 2;
        slot(0, 0, 0, 0, 3);
        slot(1, 1, 0, 0, 3);
        slot(2, 1, 0, 0, 3);
        slot(3, 1, 0, 0, 3);
        slot(0, 1, 0, 0, 3);

        phase = 3;
        blank_mask = 4'b0100;
        slot(1, 1, 0, 0, 3);
        slot(2, 1, 1, 0, 3);
        slot(3, 1, 0, 0, 3);
        slot(0, 1, 0, 0, 3);
        blank_mask = 4'b1111;
        for (int k = 1; k <= 4; k++) slot(k % 4, 1, 1, 0, 3);
        blank_mask = 4'b0000;

        phase = 4;
        slot(1, 1, 0, 0, 1);
        en = 1'b0;
        repeat (10) step(0, 4'b1111, segs[1], dp_pat[1], 2'd1);
        en = 1'b1;
        slot(1, 1, 0, 2, 3);
        slot(2, 1, 0, 0, 2);

        // Prescaler is at its terminal count here, so reset collides with a tick.
        phase = 5;
        rst = 1'b1;
        step(0, 4'b1111, 7'h00, 1'b0, 2'd0);
        rst = 1'b0;
        slot(0, 0, 0, 0, 1);

        phase = 6;
        di[6:0] = 7'h06;
        segs[0] = 7'h06;
        slot(0, 0, 0, 2, 3);
        slot(1, 1, 0, 0, 3);
        di[6:0] = 7'h3F;
        segs[0] = 7'h3F;

        phase = 7;
        step(1, 4'b1111, 7'h00, 1'b0, 2'd0);
        rst2 = 1'b0;
        for (int k = 0; k < 9; k++) begin
            step(1, lit_an[(k / 2) % 4], segs[(k / 2) % 4], dp_pat[(k / 2) % 4],
                 2'(((k + 1) / 2) % 4));
        end

        repeat (2) @(posedge clk);
        #1;
        if (q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain pending=%0d want 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
